vga_fifo_pixel_reader: RTL and testbench
========================================

// Module: vga_fifo_pixel_reader
// PURPOSE
// Read-side consumer of the pixel FIFO. Generates VGA raster timing in the pixel clock domain and pops one
// pixel per active cycle from the FIFO read port. Aligns each frame on a start-of-frame (SOF) tag carried in
// the FIFO word. Flags underflow and frame misalignment.
// PARAMETERS
// PIX_W       24   pixel colour width; FIFO word is {sof, rgb[PIX_W-1:0]}
// H_ACTIVE    640  visible pixels per line;  H_FP 16, H_SYNC 96, H_BP 48 (pixels)
// V_ACTIVE    480  visible lines per frame;  V_FP 10, V_SYNC 2,  V_BP 33 (lines)
// SYNC_POL    0    active level of vga_hsync/vga_vsync (0 = active-low)
// UFLOW_RGB   0    colour driven on an active pixel when the FIFO is empty
// PORTS
// clk            in   1        pixel clock (FIFO rd_clk)
// reset          in   1        asynchronous, active-high reset
// enable         in   1        start/keep raster running; low forces return to IDLE at next frame end
// fifo_empty     in   1        FIFO empty; when low, fifo_rd_data holds the head word (show-ahead)
// fifo_rd_data   in   PIX_W+1  head word: [PIX_W] = SOF, [PIX_W-1:0] = rgb
// fifo_rd_valid  out  1        pop strobe to FIFO rd_valid; never high while fifo_empty
// vga_rgb        out  PIX_W    pixel colour, 0 outside active region
// vga_hsync      out  1        horizontal sync
// vga_vsync      out  1        vertical sync
// vga_de         out  1        data enable (active region)
// underflow      out  1        sticky: an active pixel found the FIFO empty
// sync_err       out  1        sticky: frame start found a non-SOF head word
// err_clr        in   1        synchronous clear of both sticky flags (wins over a same-cycle set)
// BEHAVIOUR
// - Counters h_cnt 0..H_TOT-1, v_cnt 0..V_TOT-1; H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP, same for V.
// - Active when h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. Sync when cnt is in [ACTIVE+FP, ACTIVE+FP+SYNC).
// - Reset: counters 0, state IDLE, all outputs inactive (rgb=0, de=0, syncs=!SYNC_POL), flags 0.
// - States:
//   IDLE: counters held at 0, outputs blank. Pop while !fifo_empty && !SOF (discard).
//     On enable && !fifo_empty && SOF, go to RUN.
//   RUN: counters free-run. On an active cycle, fifo_rd_valid = !fifo_empty (combinational).
//     The registered vga_rgb takes rgb, or UFLOW_RGB plus underflow=1 if empty.
//     At h=0,v=0 with !fifo_empty && !SOF: set sync_err, go to RESYNC, no pop.
//     A SOF word seen mid-frame is consumed as a normal pixel.
//   RESYNC: timing continues, rgb=UFLOW_RGB on active cycles. Pop non-SOF words on any cycle.
//     At the next h=0,v=0 with SOF at the head, return to RUN and pop it as pixel (0,0).
//   Empty FIFO at h=0,v=0 in RUN: underflow set, stay in RUN, no SOF check that frame.
//   At frame wrap (h=H_TOT-1, v=V_TOT-1) with enable low, go to IDLE.
// - Latency: all video outputs registered; vga_* reflect counter state 1 clk after it. The pop and
//   its data are in the same cycle; the pixel appears on vga_rgb in the next cycle.
// - Mid-frame reset: immediate blanking. The FIFO is not flushed; IDLE discards up to the next SOF.
// CONFIGURATION
// VGA_READER_TEST_PATTERN_EN defined: adds input test_pattern (1 bit).
//   When high in RUN/RESYNC: active pixels show 8 vertical colour bars (bar = h_cnt*8/H_ACTIVE,
//   rgb = {R,G,B} each all-ones/all-zeros from bar[2:0]). No FIFO pops, no flag updates.
//   Timing is unchanged.
// Undefined: port absent, FIFO always drives video.
// TESTING (sim params H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1)
// 1 FIFO preloaded with 32 words, SOF on word0, enable=1 -> 32 pops exactly in active cycles.
//   de pattern 8-on/6-off; vsync 1 line; rgb equals words in order; no flags.
// 2 Only 20 words, then empty -> pixels 20..31 = UFLOW_RGB, underflow=1, state stays RUN.
// 3 Frame 2 head word lacks SOF -> sync_err=1; non-SOF words drained.
//   Frame 3 starting with SOF displays correctly.
// 4 In IDLE, FIFO holds 3 non-SOF words then SOF -> 3 discarded, raster starts, SOF word = pixel (0,0).
// 5 Reset asserted at h=5,v=2 for 3 clks -> outputs blank within the same edge; resync on next SOF.
// 6 err_clr pulsed in the same cycle as a new underflow -> flag reads 0 next cycle.

Source files
------------

// File: rtl/vga_fifo_pixel_reader.sv
// vga_fifo_pixel_reader
// Read side of the pixel FIFO. Runs VGA raster timing in the pixel clock
// domain and pops one show-ahead FIFO word per active pixel. Frames are
// aligned on the SOF tag in bit PIX_W of the FIFO word. Sticky flags report
// underflow and frame misalignment.
// Optional build macro VGA_READER_TEST_PATTERN_EN adds a test_pattern input
// that replaces FIFO video with 8 vertical colour bars.
module vga_fifo_pixel_reader #(
  parameter int               PIX_W     = 24,
  parameter int               H_ACTIVE  = 640,
  parameter int               H_FP      = 16,
  parameter int               H_SYNC    = 96,
  parameter int               H_BP      = 48,
  parameter int               V_ACTIVE  = 480,
  parameter int               V_FP      = 10,
  parameter int               V_SYNC    = 2,
  parameter int               V_BP      = 33,
  parameter bit               SYNC_POL  = 1'b0,
  parameter logic [PIX_W-1:0] UFLOW_RGB = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef VGA_READER_TEST_PATTERN_EN
  input  logic             test_pattern,
`endif
  input  logic             fifo_empty,
  input  logic [PIX_W:0]   fifo_rd_data,
  output logic             fifo_rd_valid,
  output logic [PIX_W-1:0] vga_rgb,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic             underflow,
  output logic             sync_err,
  input  logic             err_clr
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW   = $clog2(H_TOT + 1);
  localparam int VCW   = $clog2(V_TOT + 1);

  localparam logic [HCW-1:0] H_ACT_L  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SS_L   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SE_L   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_LAST_L = HCW'(H_TOT - 1);
  localparam logic [VCW-1:0] V_ACT_L  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SS_L   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SE_L   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_LAST_L = VCW'(V_TOT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  logic [1:0]       state, state_nx;
  logic [HCW-1:0]   h_cnt;
  logic [VCW-1:0]   v_cnt;
  logic             h_last, v_last, frame_start, frame_end;
  logic             active, h_sync_on, v_sync_on;
  logic             head_sof;
  logic [PIX_W-1:0] head_rgb;
  logic             pop;
  logic [PIX_W-1:0] rgb_nx;
  logic             set_uf, set_se;

`ifdef VGA_READER_TEST_PATTERN_EN
  logic [HCW+2:0]   h_x8;
  logic [2:0]       bar;
  logic [PIX_W-1:0] bar_rgb;
  localparam int CW = PIX_W / 3;

  // Colour bar index and colour for the current column
  always_comb begin
    h_x8    = {h_cnt, 3'b000};
    bar     = 3'(h_x8 / (HCW + 3)'(H_ACTIVE));
    bar_rgb = PIX_W'({{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}});
  end
`endif

  // Raster position decode
  always_comb begin
    h_last      = (h_cnt == H_LAST_L);
    v_last      = (v_cnt == V_LAST_L);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    frame_end   = h_last && v_last;
    active      = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    h_sync_on   = (h_cnt >= H_SS_L) && (h_cnt < H_SE_L);
    v_sync_on   = (v_cnt >= V_SS_L) && (v_cnt < V_SE_L);
    head_sof    = fifo_rd_data[PIX_W];
    head_rgb    = fifo_rd_data[PIX_W-1:0];
  end

  // Next state, pop decision, next pixel colour and flag set requests
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    rgb_nx   = '0;
    set_uf   = 1'b0;
    set_se   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !head_sof)
          pop = 1'b1;
        else if (enable && !fifo_empty)
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (frame_start && !fifo_empty && !head_sof) begin
          set_se   = 1'b1;
          state_nx = ST_RESYNC;
          rgb_nx   = UFLOW_RGB;
        end else if (active) begin
          if (fifo_empty) begin
            rgb_nx = UFLOW_RGB;
            set_uf = 1'b1;
          end else begin
            pop    = 1'b1;
            rgb_nx = head_rgb;
          end
        end
      end
      ST_RESYNC: begin
        if (frame_start && !fifo_empty && head_sof) begin
          pop      = 1'b1;
          rgb_nx   = head_rgb;
          state_nx = ST_RUN;
        end else begin
          pop = !fifo_empty && !head_sof;
          if (active)
            rgb_nx = UFLOW_RGB;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
`ifdef VGA_READER_TEST_PATTERN_EN
    // Bars take over the video path; the FIFO and flags are left untouched
    if (test_pattern && state != ST_IDLE) begin
      pop      = 1'b0;
      set_uf   = 1'b0;
      set_se   = 1'b0;
      state_nx = state;
      rgb_nx   = active ? bar_rgb : '0;
    end
`endif
    if (state != ST_IDLE && frame_end && !enable)
      state_nx = ST_IDLE;
  end

  // No pop while reset holds the reader in IDLE
  assign fifo_rd_valid = pop & ~reset;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Raster counters: held at zero in IDLE, free-running otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == ST_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered video outputs, one clock behind the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_rgb   <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
    end else if (state == ST_IDLE) begin
      vga_rgb   <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
    end else begin
      vga_rgb   <= rgb_nx;
      vga_de    <= active;
      vga_hsync <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= v_sync_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (err_clr)     underflow <= 1'b0;
      else if (set_uf) underflow <= 1'b1;
      if (err_clr)     sync_err  <= 1'b0;
      else if (set_se) sync_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fifo_pixel_reader.sv
// Testbench for vga_fifo_pixel_reader with a reduced raster (14x7 totals).
// The FIFO is a queue; a frame-position reference model predicts pops and
// the registered video outputs, and a monitor compares them each cycle.
module tb_vga_fifo_pixel_reader;
  localparam int PIX_W = 24;
  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;
  localparam logic [PIX_W-1:0] UF_RGB = 24'h5AA53C;

  typedef struct packed {
    logic [PIX_W-1:0] rgb;
    logic de; logic hs; logic vs; logic uf; logic se;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             err_clr = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [PIX_W:0]   fifo_rd_data = '0;
  logic             fifo_rd_valid;
  logic [PIX_W-1:0] vga_rgb;
  logic             vga_hsync, vga_vsync, vga_de, underflow, sync_err;
`ifdef VGA_READER_TEST_PATTERN_EN
  logic             test_pattern = 1'b0;
`endif

  // Requested input values, applied mid-cycle by cyc()
  bit rst_r = 1'b1, en_r = 1'b0, clr_r = 1'b0;

  logic [PIX_W:0] fq[$];
  exp_t           exp_q[$];
  int             errors = 0, checks = 0, pops = 0;

  // Reference model: mode 0 idle, 1 showing, 2 waiting for SOF; linear frame position
  int m_mode = 0, m_pos = 0;
  bit m_uf = 1'b0, m_se = 1'b0;

  always #5 clk = ~clk;

  vga_fifo_pixel_reader #(
    .PIX_W(PIX_W), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .UFLOW_RGB(UF_RGB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef VGA_READER_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid),
    .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .underflow(underflow), .sync_err(sync_err), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model(input bit emp, input logic [PIX_W:0] head, output bit pop, output exp_t e);
    int h, v, nmode;
    bit act, sof, first, set_uf, set_se;
    h = m_pos % HT; v = m_pos / HT;
    sof = head[PIX_W]; first = (m_pos == 0);
    set_uf = 0; set_se = 0; nmode = m_mode; pop = 0;
    e = '{rgb: '0, de: 1'b0, hs: 1'b1, vs: 1'b1, uf: 1'b0, se: 1'b0};
    if (rst_r) begin
      m_mode = 0; m_pos = 0; m_uf = 0; m_se = 0;
      return;
    end
    if (m_mode == 0) begin
      if (!emp && !sof) pop = 1;
      else if (en_r && !emp) nmode = 1;
    end else begin
      act  = (h < HA) && (v < VA);
      e.de = act;
      e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      if (m_mode == 1) begin
        if (first && !emp && !sof) begin set_se = 1; nmode = 2; e.rgb = UF_RGB; end
        else if (act && emp) begin set_uf = 1; e.rgb = UF_RGB; end
        else if (act) begin pop = 1; e.rgb = head[PIX_W-1:0]; end
      end else begin
        if (first && !emp && sof) begin pop = 1; e.rgb = head[PIX_W-1:0]; nmode = 1; end
        else begin pop = !emp && !sof; if (act) e.rgb = UF_RGB; end
      end
      if (m_pos == FR - 1 && !en_r) nmode = 0;
    end
    if (clr_r) m_uf = 0; else if (set_uf) m_uf = 1;
    if (clr_r) m_se = 0; else if (set_se) m_se = 1;
    m_pos  = (m_mode == 0) ? 0 : (m_pos + 1) % FR;
    m_mode = nmode;
    e.uf = m_uf; e.se = m_se;
  endtask

  // One pixel clock: drive inputs mid-cycle, predict, then follow the DUT's pop
  task automatic cyc();
    exp_t e;
    bit mpop, emp, dpop;
    logic [PIX_W:0] head;
    @(negedge clk);
    #1;
    reset = rst_r; enable = en_r; err_clr = clr_r;
    emp  = (fq.size() == 0);
    head = emp ? '0 : fq[0];
    fifo_empty = emp; fifo_rd_data = head;
    #1;
    model(emp, head, mpop, e);
    check("pop_strobe", 64'(fifo_rd_valid), 64'(mpop));
    if (rst_r)
      check("rst_async_blank", 64'({vga_rgb, vga_de, vga_hsync, vga_vsync}), 64'({24'h0, 3'b011}));
    exp_q.push_back(e);
    dpop = fifo_rd_valid;
    @(posedge clk);
    if (dpop && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_frame(input int junk, input int n, input bit sof0);
    for (int i = 0; i < junk; i++) fq.push_back({1'b0, 24'($urandom)});
    for (int i = 0; i < n; i++) fq.push_back({1'((i == 0) && sof0), 24'($urandom)});
  endtask

  // Monitor: every cycle the registered outputs must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("video_out", 64'({vga_rgb, vga_de, vga_hsync, vga_vsync, underflow, sync_err}), 64'(e));
      end
    end
  end

  initial begin
    // Reset state
    run(3);
    #2 check("reset_state", 64'({vga_rgb, vga_de, vga_hsync, vga_vsync, underflow, sync_err}),
             64'({24'h0, 5'b01100}));
    rst_r = 0;

    // Two clean frames from a preloaded FIFO
    push_frame(0, 32, 1); push_frame(0, 32, 1);
    en_r = 1; pops = 0;
    run(1 + 2 * FR);
    #2 check("clean_pops", 64'(pops), 64'(64));
    check("clean_flags", 64'({underflow, sync_err}), 64'(0));

    // Short frame underflows
    pops = 0;
    push_frame(0, 20, 1);
    run(FR - 2);
    #2 check("short_pops", 64'(pops), 64'(20));
    check("short_uf", 64'(underflow), 64'(1));
    clr_r = 1; run(1); clr_r = 0; run(1);
    #2 check("uf_cleared", 64'(underflow), 64'(0));
    // Clear coincides with an underflow at frame start
    clr_r = 1; run(1); clr_r = 0;
    #2 check("clr_wins", 64'(underflow), 64'(0));
    run(FR - 2);
    clr_r = 1; run(1); clr_r = 0;

    // Misaligned frame followed by an aligned one
    push_frame(0, 32, 0); push_frame(0, 32, 1);
    run(2 * FR);
    #2 check("resync_err", 64'({underflow, sync_err}), 64'(2'b01));
    check("resync_drained", 64'(fq.size()), 64'(0));

    // Drop to IDLE, then discard 3 stale words before the SOF
    en_r = 0; run(FR);
    clr_r = 1; run(1); clr_r = 0;
    pops = 0; push_frame(3, 32, 1); en_r = 1;
    run(3 + 1 + FR);
    #2 check("idle_pops", 64'(pops), 64'(35));
    check("idle_flags", 64'({underflow, sync_err}), 64'(0));

    // Reset mid-frame at h=5, v=2 for three clocks
    push_frame(0, 32, 1);
    run(2 * HT + 5);
    rst_r = 1; run(3);
    #2 check("midrst_blank", 64'({vga_rgb, vga_de, vga_hsync, vga_vsync}), 64'({24'h0, 3'b011}));
    rst_r = 0;
    check("midrst_left", 64'(fq.size()), 64'(11));
    push_frame(0, 32, 1);
    run(11 + 1 + FR);
    #2 check("midrst_drained", 64'(fq.size()), 64'(0));
    check("midrst_flags", 64'({underflow, sync_err}), 64'(0));

    // Random frame sizes, SOF placement and flag clears
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(24, 40);
      for (int i = 0; i < n; i++)
        fq.push_back({1'((i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0)),
                      24'($urandom)});
      for (int c = 0; c < FR; c++) begin
        clr_r = ($urandom_range(0, 39) == 0);
        cyc();
      end
    end
    clr_r = 0;

    @(negedge clk);
    #1 check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
